// File: rtl/mips_io_pkg.sv
// mips_io_pkg: shared LED I/O address, monitor FSM states and seven-segment table
package mips_io_pkg;
  localparam logic [31:0] LED_IO_ADDR = 32'h0000_002C;
  typedef enum logic {IDLE, SHOW} state_e;
  localparam logic [15:0][6:0] SEG7_TBL = {
    7'b1110001, 7'b1111001, 7'b1011110, 7'b0111001,
    7'b1111100, 7'b1110111, 7'b1101111, 7'b1111111,
    7'b0000111, 7'b1111101, 7'b1101101, 7'b1100110,
    7'b1001111, 7'b1011011, 7'b0000110, 7'b0111111
  };
endpackage

// File: rtl/hex_to_seg7.sv
// hex_to_seg7: active-high {g,f,e,d,c,b,a} decode of one hex nibble
module hex_to_seg7
  import mips_io_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  assign seg = SEG7_TBL[nib];
endmodule

// File: rtl/store_led_monitor.sv
// store_led_monitor: captures stores to the LED address and shows them nibble by nibble
module store_led_monitor
  import mips_io_pkg::*;
#(
  parameter logic [31:0] IO_ADDR     = LED_IO_ADDR,
  parameter int unsigned HOLD_CYCLES = 4,
  parameter bit          ACTIVE_LOW  = 1'b1
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        En,
  input  logic        MemWrite,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [6:0]  Led,
  output logic [2:0]  Digit,
  output logic        Busy,
  output logic        Overrun
);
  localparam logic [15:0] LAST = 16'(HOLD_CYCLES - 1);
  localparam logic [6:0]  POL  = ACTIVE_LOW ? 7'h7F : 7'h00;
  state_e      state_q, state_d;
  logic [31:0] cur_q, cur_d, pend_q, pend_d;
  logic        pend_v_q, pend_v_d, ovr_q, ovr_d;
  logic [2:0]  dig_q, dig_d;
  logic [15:0] cnt_q, cnt_d;
  logic [6:0]  led_q, led_d, seg;
  logic        hit, tick, done;
  assign hit  = En && MemWrite && Addr == IO_ADDR;
  assign tick = cnt_q == LAST;
  assign done = state_q == SHOW && tick && dig_q == 3'd0;
  // Decode from next-state values so Led stays registered yet in step with Digit.
  hex_to_seg7 u_seg (
    .nib(cur_d[{dig_d, 2'b00} +: 4]),
    .seg(seg)
  );
  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    ovr_d    = ovr_q;
    dig_d    = dig_q;
    cnt_d    = cnt_q;
    if (En) begin
      if (state_q == IDLE) begin
        if (hit) begin
          state_d = SHOW;
          cur_d   = WriteData;
          dig_d   = 3'd7;
          cnt_d   = '0;
        end
      end else if (done) begin
        cnt_d = '0;
        dig_d = 3'd7;
        if (pend_v_q) begin
          cur_d    = pend_q;
          pend_v_d = hit;
          pend_d   = hit ? WriteData : pend_q;
        end else if (hit) begin
          cur_d = WriteData;
        end else begin
          state_d = IDLE;
          dig_d   = 3'd0;
        end
      end else begin
        cnt_d = tick ? '0 : cnt_q + 16'd1;
        dig_d = tick ? dig_q - 3'd1 : dig_q;
        if (hit && pend_v_q) ovr_d = 1'b1;
        else if (hit) begin
          pend_d   = WriteData;
          pend_v_d = 1'b1;
        end
      end
    end
    led_d = seg ^ POL;
  end
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q  <= IDLE;
      cur_q    <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      ovr_q    <= 1'b0;
      dig_q    <= 3'd0;
      cnt_q    <= '0;
      led_q    <= SEG7_TBL[0] ^ POL;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      ovr_q    <= ovr_d;
      dig_q    <= dig_d;
      cnt_q    <= cnt_d;
      led_q    <= led_d;
    end
  end
  assign Led     = led_q;
  assign Digit   = dig_q;
  assign Busy    = state_q == SHOW;
  assign Overrun = ovr_q;
endmodule

// File: doc/store_led_monitor.md
# store_led_monitor

Memory-mapped output monitor that sits downstream of the MIPS core's data-memory write port, next to the data memory. It snoops store transactions. When a store targets the LED I/O address, it captures the 32-bit word and plays it out on the 7-segment `Led` port one hex nibble at a time, most significant first, holding each digit for a programmable number of cycles. This makes program results such as the final `sw` to address 0x2C visible on the board.

## Interface
- `IO_ADDR`, 32'h0000002C, byte address that triggers capture (full 32-bit equality).
- `HOLD_CYCLES`, 4, cycles each nibble is displayed (≥1, fits 16 bits).
- `ACTIVE_LOW`, 1, 1 = segment on drives 0.
- `Clk`  in  1  system clock, rising edge.
- `Rst`  in  1  reset, asynchronous, active-high.
- `En`  in  1  block enable; low freezes all state and ignores stores.
- `MemWrite`  in  1  data-memory write strobe from core.
- `Addr`  in  32  data-memory byte address.
- `WriteData`  in  32  store data.
- `Led`  out  7  segments {g,f,e,d,c,b,a}, registered.
- `Digit`  out  3  index of nibble currently shown (7 = bits 31:28).
- `Busy`  out  1  high while playing out a word.
- `Overrun`  out  1  sticky: a store was dropped.

## Operation
- Hit means `En && MemWrite && Addr == IO_ADDR`, sampled at the rising edge.
- Storage: `cur` (32 b) holds the word being shown; `pend` (32 b) plus `pend_v` form a one-deep queue.
- FSM has two states, IDLE and SHOW.
- IDLE + hit:
  - load `cur` ← WriteData, `Digit` ← 7, hold counter ← 0, go to SHOW.
- SHOW:
  - hold counter increments each enabled cycle.
  - At HOLD_CYCLES−1, counter clears and `Digit` decrements.
  - When the hold expires at `Digit` = 0, the word is finished.
- Word finished:
  - if `pend_v`: `cur` ← `pend`, clear `pend_v`, `Digit` ← 7, stay in SHOW (no IDLE cycle).
  - else if a hit arrives that same cycle: load it directly as above.
  - else go to IDLE.
- Hit in SHOW (not on a finishing cycle):
  - if `!pend_v`: `pend` ← WriteData, set `pend_v`.
  - else drop the new word and set `Overrun`. The first queued word is kept.
- Hit on a finishing cycle while `pend_v`: the pending word loads and the new hit is treated as above (it is queued, since `pend_v` clears at the same time).
- `Led` = seg7(`cur[4*Digit +: 4]`), inverted when ACTIVE_LOW.
- In IDLE, `Led` keeps showing nibble 0 of the last word.
- Active-high encodings: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001.
- `En` low: no state changes and hits are ignored; outputs hold their values.
- `Overrun` clears only on reset.

## Timing
- Reset values: state IDLE, `cur` = 0, `pend_v` = 0, `Digit` = 0, `Busy` = 0, `Overrun` = 0.
  - `Led` = seg7(0): 1000000 when ACTIVE_LOW, 0111111 otherwise.
- Latency: hit sampled at edge k → `Led`/`Digit` = 7 / `Busy` = 1 valid after edge k.
- Each nibble is visible for exactly HOLD_CYCLES enabled cycles. A full word takes 8×HOLD_CYCLES cycles.
- Back-to-back words (pending, or a hit on the finishing cycle) have a zero-cycle gap.
- `Busy` falls on the edge that enters IDLE.
- Reset asserted mid-word returns all outputs to reset values immediately (asynchronous). The pending word is lost.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `mips_io_pkg` holds:
  - the `LED_IO_ADDR` = 32'h2C constant;
  - the FSM state typedef (IDLE, SHOW);
  - the 16-entry seg7 encoding constant.
- Sub-module `hex_to_seg7` (combinational, 4→7, active-high) is instantiated once. The polarity inversion stays in the parent.

## Test plan
- Reset only: `Led` = 1000000, `Digit` = 0, `Busy` = 0, `Overrun` = 0.
- Store 0x1234ABCD to 0x2C, HOLD_CYCLES = 4:
  - `Digit` 7→0, 4 cycles each, `Led` sequence 1111001, 0100100, 0110000, 0011001, 0001000, 0000011, 1000110, 0100001;
  - `Busy` low after 32 cycles, `Led` stays 0100001.
- Store to 0x28 and a read (MemWrite = 0) at 0x2C: no state change.
- Store A = 0x11111111, then B = 0x22222222 10 cycles later, then C = 0x33333333:
  - A plays fully, B follows with zero gap, C is dropped, `Overrun` = 1.
- Store on A's final cycle with an empty queue: the new word starts at `Digit` 7 on the next cycle and `Busy` never drops.
- `En` held low for 5 cycles mid-digit: `Digit`/`Led` frozen and the display resumes with the remaining hold count. Then assert `Rst` mid-word: immediate reset values, and the queued word does not appear afterwards.
